// File: rtl/xor_arb_pkg.sv
// Shared types and width helpers for the round-robin XOR arbiter.
package xor_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Index width for a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the latency counter; it only has to reach LAT-1.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/xor_unit.sv
// Shared combinational XOR datapath; registering is owned by the arbiter.
module xor_unit #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_rr_arbiter.sv
// Round-robin arbiter sharing one XOR unit between NREQ requesters.
// One operation per LAT+2 cycles: IDLE (grant), LAT cycles BUSY, one DONE (ack).
module xor_rr_arbiter
  import xor_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  parameter  int LAT  = 1,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      result,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  localparam int CW = cnt_width(LAT);

  arb_state_e     state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [W-1:0]   op_a, op_b, xor_y;
  logic           cnt_last;

  assign cnt_last = (cnt == CW'(LAT - 1));
  assign busy     = (state != IDLE);

  // Round-robin pick: first set req bit after ptr, wrapping; previous winner is lowest.
  always_comb begin
    int idx;
    logic found;
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: req only matters in IDLE; BUSY/DONE run to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)    state_nxt = BUSY;
      BUSY:    if (cnt_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture at grant, result/ack at the end of BUSY, pointer update in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      cnt      <= '0;
      ptr      <= IDW'(NREQ - 1);
      grant_id <= '0;
      result   <= '0;
      ack      <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (|req) begin
            op_a     <= a_bus[int'(win)*W +: W];
            op_b     <= b_bus[int'(win)*W +: W];
            grant_id <= win;
            cnt      <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (cnt_last) begin
            result <= xor_y;
            ack    <= NREQ'(1) << grant_id;
          end
        end
        DONE: begin
          ack <= '0;
          ptr <= grant_id;
        end
        default: ack <= '0;
      endcase
    end
  end

  xor_unit #(.W(W)) u_xor (
    .a (op_a),
    .b (op_b),
    .y (xor_y)
  );

endmodule

// File: tb/tb_xor_rr_arbiter.sv
// Directed bench: one LAT=1/W=8 instance and one LAT=3/W=16 instance.
module tb_xor_rr_arbiter;

  logic        clk;
  int          n_cmp, n_err;

  // LAT=1, W=8 instance
  logic        rst1;
  logic [3:0]  req1, ack1;
  logic [31:0] a1, b1;
  logic [7:0]  res1;
  logic [1:0]  gid1;
  logic        busy1;

  // LAT=3, W=16 instance
  logic        rst3;
  logic [3:0]  req3, ack3;
  logic [63:0] a3, b3;
  logic [15:0] res3;
  logic [1:0]  gid3;
  logic        busy3;

  xor_rr_arbiter #(.NREQ(4), .W(8), .LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .a_bus(a1), .b_bus(b1),
    .ack(ack1), .result(res1), .grant_id(gid1), .busy(busy1)
  );

  xor_rr_arbiter #(.NREQ(4), .W(16), .LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .a_bus(a3), .b_bus(b3),
    .ack(ack3), .result(res3), .grant_id(gid3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until ack1 rises (bounded); cyc = edges taken.
  task automatic wait_ack1(input int bound, output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (ack1 == 4'b0 && cyc < bound);
    if (ack1 == 4'b0) chk("ack1_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ack3(input int bound, output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (ack3 == 4'b0 && cyc < bound);
    if (ack3 == 4'b0) chk("ack3_timeout", 32'd0, 32'd1);
  endtask

  // Expected contention order and results: a_i = 11*(i+1), b_i = 0F
  logic [3:0] exp_ack4 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] exp_res4 [5] = '{8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h1E};
  logic [3:0] exp_ack2 [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
  logic [7:0] exp_res2 [4] = '{8'h1E, 8'h3C, 8'h1E, 8'h3C};

  initial begin
    int cyc, bcnt, atick;
    logic [15:0] r3;
    logic [3:0]  a3v;
    n_cmp = 0; n_err = 0;
    rst1 = 1'b1; req1 = '0; a1 = '0; b1 = '0;
    rst3 = 1'b1; req3 = '0; a3 = '0; b3 = '0;
    tick(); tick();
    // reset state
    chk("rst_ack",   32'(ack1),  32'h0);
    chk("rst_res",   32'(res1),  32'h0);
    chk("rst_gid",   32'(gid1),  32'h0);
    chk("rst_busy",  32'(busy1), 32'h0);

    // 1: single requester
    rst1 = 1'b0;
    req1 = 4'b0001; a1[7:0] = 8'hA5; b1[7:0] = 8'h0F;
    tick();
    chk("t1_busy", 32'(busy1), 32'h1);
    chk("t1_gid",  32'(gid1),  32'h0);
    chk("t1_noack", 32'(ack1), 32'h0);
    tick();
    chk("t1_ack", 32'(ack1), 32'h1);
    chk("t1_res", 32'(res1), 32'hAA);
    req1 = '0;
    tick();
    chk("t1_ackoff", 32'(ack1),  32'h0);
    chk("t1_idle",   32'(busy1), 32'h0);
    chk("t1_hold",   32'(res1),  32'hAA);

    // 2: contention, all requesters held
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    a1 = {8'h44, 8'h33, 8'h22, 8'h11}; b1 = {4{8'h0F}};
    req1 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack1(8, cyc);
      chk($sformatf("t2_ack%0d", i), 32'(ack1), 32'(exp_ack4[i]));
      chk($sformatf("t2_res%0d", i), 32'(res1), 32'(exp_res4[i]));
      chk($sformatf("t2_gap%0d", i), 32'(cyc), (i == 0) ? 32'd2 : 32'd3);
    end
    req1 = '0; tick();

    // 3: fairness with 0101
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    req1 = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_ack1(8, cyc);
      chk($sformatf("t3_ack%0d", i), 32'(ack1), 32'(exp_ack2[i]));
      chk($sformatf("t3_res%0d", i), 32'(res1), 32'(exp_res2[i]));
    end
    req1 = '0; tick();

    // 5: drop req and corrupt operand during BUSY
    rst1 = 1'b1; tick(); rst1 = 1'b0;
    a1[15:8] = 8'hFF; b1[15:8] = 8'h00;
    req1 = 4'b0010;
    tick();
    chk("t5_gid", 32'(gid1), 32'h1);
    req1 = '0; a1[15:8] = 8'h00;
    tick();
    chk("t5_ack", 32'(ack1), 32'h2);
    chk("t5_res", 32'(res1), 32'hFF);
    tick();
    chk("t5_ackoff", 32'(ack1), 32'h0);
    chk("t5_idle",   32'(busy1), 32'h0);

    // 4: reset during BUSY, LAT=3
    rst3 = 1'b0;
    a3[47:32] = 16'h00F0; b3[47:32] = 16'h0F00;
    req3 = 4'b0100;
    tick();
    chk("t4_gid", 32'(gid3), 32'h2);
    req3 = '0;
    tick();
    chk("t4_noack", 32'(ack3), 32'h0);
    rst3 = 1'b1;
    tick();
    chk("t4_ack",  32'(ack3),  32'h0);
    chk("t4_res",  32'(res3),  32'h0);
    chk("t4_gid0", 32'(gid3),  32'h0);
    chk("t4_busy", 32'(busy3), 32'h0);
    rst3 = 1'b0;
    req3 = 4'b0100;
    wait_ack3(10, cyc);
    chk("t4_ack2", 32'(ack3), 32'h4);
    chk("t4_res2", 32'(res3), 32'h0FF0);
    chk("t4_lat",  32'(cyc),  32'd4);
    req3 = '0; tick();

    // 6: latency and busy width, LAT=3 W=16
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    a3[15:0] = 16'h1234; b3[15:0] = 16'hFFFF;
    req3 = 4'b0001;
    bcnt = 0; atick = 0; r3 = '0; a3v = '0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (busy3) bcnt++;
      if (ack3 != 4'b0 && atick == 0) begin
        atick = t; r3 = res3; a3v = ack3; req3 = '0;
      end
    end
    chk("t6_lat",  32'(atick), 32'd4);
    chk("t6_ack",  32'(a3v),   32'h1);
    chk("t6_res",  32'(r3),    32'hEDCB);
    chk("t6_busy", 32'(bcnt),  32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
